mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single-port memory with fixed read latency.
// One access in flight at a time; round-robin when both requesters are eligible.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              if_done,
   output logic              d_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              if_stall,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   localparam logic [3:0] LatInit = 4'(MEM_LAT);

   state_e     state_q;
   logic       last_gnt_q;  // 0: fetch granted last, 1: data granted last
   logic [3:0] cnt_q;
   logic       we_q;

   logic elig_i, elig_d, gnt_i, gnt_d;

   assign if_stall = if_req & ~if_done;
   assign d_stall  = d_req & ~d_done;

   // A requester being acknowledged this cycle must not be re-granted on the same request.
   assign elig_i = if_req & ~if_done;
   assign elig_d = d_req & ~d_done;
   assign gnt_d  = elig_d & (~elig_i | ~last_gnt_q);
   assign gnt_i  = elig_i & ~gnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         last_gnt_q <= 1'b0;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_done    <= 1'b0;
         d_done     <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (gnt_d) begin
                  state_q    <= StBusyD;
                  last_gnt_q <= 1'b1;
                  cnt_q      <= LatInit;
                  we_q       <= d_we;
                  mem_en     <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
               end else if (gnt_i) begin
                  state_q    <= StBusyI;
                  last_gnt_q <= 1'b0;
                  cnt_q      <= LatInit;
                  we_q       <= 1'b0;
                  mem_en     <= 1'b1;
                  mem_addr   <= if_addr;
               end
            end
            StBusyI, StBusyD: begin
               // Counter reaches zero in the cycle mem_rdata is valid.
               if (cnt_q == 4'd0) begin
                  state_q <= StIdle;
                  if (state_q == StBusyI) begin
                     if_done  <= 1'b1;
                     if_rdata <= mem_rdata;
                  end else begin
                     d_done <= 1'b1;
                     if (!we_q) d_rdata <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=2) with a fixed-content memory model.
// Cycle n is the clock period that begins at the n-th edge of each scenario loop.
module tb_mem_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          if_done, d_done, if_stall, d_stall;
   logic [DW-1:0] if_rdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .if_done  (if_done),
      .d_done   (d_done),
      .if_rdata (if_rdata),
      .d_rdata  (d_rdata),
      .if_stall (if_stall),
      .d_stall  (d_stall),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      case (a)
         9'h004:  return 32'h0050_0093;
         9'h008:  return 32'h00A0_0113;
         9'h020:  return 32'h1234_5678;
         9'h030:  return 32'hCAFE_F00D;
         default: return 32'h0;
      endcase
   endfunction

   // Two-stage read pipeline: data is on mem_rdata two cycles after the mem_en cycle.
   logic          p1_v = 1'b0, p2_v = 1'b0;
   logic [AW-1:0] p1_a = '0, p2_a = '0;
   always @(posedge clk) begin
      p1_v <= mem_en & ~mem_we;
      p1_a <= mem_addr;
      p2_v <= p1_v;
      p2_a <= p1_a;
   end
   assign mem_rdata = p2_v ? mem_word(p2_a) : 32'h0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_mem(input string tag, input int c, input logic en,
                          input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
      check_eq($sformatf("%s c%0d mem_en", tag, c), 64'(mem_en), 64'(en));
      check_eq($sformatf("%s c%0d mem_addr", tag, c), 64'(mem_addr), en ? 64'(a) : 64'h0);
      check_eq($sformatf("%s c%0d mem_we", tag, c), 64'(mem_we), en ? 64'(we) : 64'h0);
      check_eq($sformatf("%s c%0d mem_wdata", tag, c), 64'(mem_wdata), en ? 64'(wd) : 64'h0);
   endtask

   task automatic chk_done(input string tag, input int c, input logic idone, input logic ddone);
      check_eq($sformatf("%s c%0d if_done", tag, c), 64'(if_done), 64'(idone));
      check_eq($sformatf("%s c%0d d_done", tag, c), 64'(d_done), 64'(ddone));
      check_eq($sformatf("%s c%0d if_stall", tag, c), 64'(if_stall), 64'(if_req & ~idone));
      check_eq($sformatf("%s c%0d d_stall", tag, c), 64'(d_stall), 64'(d_req & ~ddone));
   endtask

   initial begin
      reset = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      step();
      step();
      #2;
      chk_mem("reset", 0, 1'b0, '0, 1'b0, '0);
      chk_done("reset", 0, 1'b0, 1'b0);
      check_eq("reset if_rdata", 64'(if_rdata), 64'h0);
      check_eq("reset d_rdata", 64'(d_rdata), 64'h0);

      // Single fetch; first cycle out of reset grants.
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) begin reset = 1'b0; if_req = 1'b1; if_addr = 9'h004; end
         if (c == 6) if_req = 1'b0;
         #2;
         chk_mem("fetch", c, c == 2, 9'h004, 1'b0, '0);
         chk_done("fetch", c, c == 5, 1'b0);
         if (c >= 5) check_eq($sformatf("fetch c%0d if_rdata", c), 64'(if_rdata), 64'h0050_0093);
      end

      // Data load then store; the store must not disturb d_rdata.
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; d_wdata = '0; end
         if (c == 6) begin d_we = 1'b1; d_addr = 9'h010; d_wdata = 32'hDEAD_BEEF; end
         if (c == 11) d_req = 1'b0;
         #2;
         if (c <= 5) chk_mem("ldst", c, c == 2, 9'h020, 1'b0, '0);
         else        chk_mem("ldst", c, c == 7, 9'h010, 1'b1, 32'hDEAD_BEEF);
         chk_done("ldst", c, 1'b0, c == 5 || c == 10);
         if (c >= 5) check_eq($sformatf("ldst c%0d d_rdata", c), 64'(d_rdata), 64'h1234_5678);
      end

      // Both requesting: D first after reset, then alternate.
      reset = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         if (c == 1) begin
            reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            if_addr = 9'h008; d_addr = 9'h030; d_wdata = '0;
         end
         if (c == 13) if_req = 1'b0;
         if (c == 14) d_req = 1'b0;
         #2;
         chk_mem("rr", c, c == 2 || c == 6 || c == 10, (c == 6) ? 9'h008 : 9'h030, 1'b0, '0);
         chk_done("rr", c, c == 9, c == 5 || c == 13);
         if (c == 5) check_eq("rr c5 d_rdata", 64'(d_rdata), 64'hCAFE_F00D);
         if (c == 9) check_eq("rr c9 if_rdata", 64'(if_rdata), 64'h00A0_0113);
      end

      // Held fetch alone: the done cycle is not a grant cycle, so next access starts one later.
      reset = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 1) begin reset = 1'b0; if_req = 1'b1; if_addr = 9'h008; end
         if (c == 11) if_req = 1'b0;
         #2;
         chk_mem("b2b", c, c == 2 || c == 7, 9'h008, 1'b0, '0);
         chk_done("b2b", c, c == 5 || c == 10, 1'b0);
         if (c == 10) check_eq("b2b c10 if_rdata", 64'(if_rdata), 64'h00A0_0113);
      end

      // Reset mid-fetch: access dropped, late mem_rdata ignored.
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) begin if_req = 1'b1; if_addr = 9'h004; end
         if (c == 3) begin reset = 1'b1; if_req = 1'b0; end
         if (c == 4) reset = 1'b0;
         #2;
         chk_mem("rstmid", c, c == 2, 9'h004, 1'b0, '0);
         chk_done("rstmid", c, 1'b0, 1'b0);
         check_eq($sformatf("rstmid c%0d if_rdata", c), 64'(if_rdata),
                  (c <= 3) ? 64'h00A0_0113 : 64'h0);
      end

      // Request withdrawn while busy still completes exactly once.
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; d_wdata = '0; end
         if (c == 2) d_req = 1'b0;
         #2;
         chk_mem("wdraw", c, c == 2, 9'h020, 1'b0, '0);
         chk_done("wdraw", c, 1'b0, c == 5);
         if (c >= 5) check_eq($sformatf("wdraw c%0d d_rdata", c), 64'(d_rdata), 64'h1234_5678);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
